// File: rtl/mem_access_ctrl_if.sv
// Bundle of MEM-stage request, dcache handshake and pipeline-control signals
// seen by the memory access controller.
interface mem_access_ctrl_if;
   // Pipeline MEM-stage request
   logic        mem_valid;
   logic        dren_mem;
   logic        dwen_mem;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        flush;
   logic        advance;
   // Dcache side
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [3:0]  dmembyteen;
   // Results and pipeline control
   logic [31:0] dmemload_mem;
   logic        mem_stall;
   logic        mem_done;
   logic        misaligned_fault;
   logic        bus_error;

   modport slave (
      input  mem_valid, dren_mem, dwen_mem, funct3, addr, store_data, flush, advance,
      input  dhit, dmemload,
      output dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
      output dmemload_mem, mem_stall, mem_done, misaligned_fault, bus_error
   );

   modport master (
      output mem_valid, dren_mem, dwen_mem, funct3, addr, store_data, flush, advance,
      output dhit, dmemload,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
      input  dmemload_mem, mem_stall, mem_done, misaligned_fault, bus_error
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues word-addressed dcache requests, aligns and
// extends load data, and holds the result until the MEM/WB latch advances.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               CLK,
   input  logic               nRST,
   mem_access_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic        is_load_q, is_load_d;
   logic [31:0] store_q, store_d;
   logic [3:0]  byteen_q, byteen_d;
   logic [31:0] cnt_q, cnt_d;
   logic        flushed_q, flushed_d;
   logic [31:0] result_q, result_d;
   logic        fault_q, fault_d;
   logic        buserr_q, buserr_d;

   logic        req_valid;
   logic        accept;
   logic        f3_ok;
   logic        align_ok;
   logic        legal;
   logic [3:0]  lane_byteen;
   logic [31:0] lane_store;
   logic [31:0] load_shift;
   logic [31:0] load_ext;
   logic [31:0] cnt_inc;
   logic        timeout;

   assign req_valid = bus.mem_valid & (bus.dren_mem | bus.dwen_mem) & ~bus.flush;
   assign accept    = req_valid &
                      ((state_q == StIdle) | ((state_q == StDone) & bus.advance));

   // Decode legality of the incoming request; dren and dwen together is never legal.
   always_comb begin
      f3_ok = 1'b0;
      if (bus.dren_mem && !bus.dwen_mem) begin
         case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else if (bus.dwen_mem && !bus.dren_mem) begin
         case (bus.funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
      case (bus.funct3[1:0])
         2'b01:   align_ok = ~bus.addr[0];
         2'b10:   align_ok = (bus.addr[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
   end

   assign legal = f3_ok & align_ok;

   always_comb begin
      lane_byteen = 4'b0000;
      lane_store  = bus.store_data;
      case (bus.funct3[1:0])
         2'b00: begin
            lane_byteen = 4'b0001 << bus.addr[1:0];
            lane_store  = {4{bus.store_data[7:0]}};
         end
         2'b01: begin
            lane_byteen = bus.addr[1] ? 4'b1100 : 4'b0011;
            lane_store  = {2{bus.store_data[15:0]}};
         end
         default: begin
            lane_byteen = 4'b1111;
            lane_store  = bus.store_data;
         end
      endcase
      if (!bus.dwen_mem) begin
         lane_byteen = 4'b0000;
      end
   end

   assign load_shift = bus.dmemload >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
         3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
         3'b100:  load_ext = {24'd0, load_shift[7:0]};
         3'b101:  load_ext = {16'd0, load_shift[15:0]};
         default: load_ext = bus.dmemload;
      endcase
   end

   assign cnt_inc = cnt_q + 32'd1;
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CYCLES);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      f3_d      = f3_q;
      is_load_d = is_load_q;
      store_d   = store_q;
      byteen_d  = byteen_q;
      cnt_d     = cnt_q;
      flushed_d = flushed_q;
      result_d  = result_q;
      fault_d   = fault_q;
      buserr_d  = buserr_q;

      case (state_q)
         StIdle: ;
         StReq: begin
            if (bus.flush) begin
               flushed_d = 1'b1;
            end
            // A flushed transaction still runs to dhit/timeout, then retires silently.
            if (bus.dhit) begin
               if (flushed_q || bus.flush) begin
                  state_d  = StIdle;
                  result_d = 32'd0;
               end else begin
                  state_d  = StDone;
                  result_d = is_load_q ? load_ext : 32'd0;
               end
            end else begin
               cnt_d = cnt_inc;
               if (timeout) begin
                  result_d = 32'd0;
                  if (flushed_q || bus.flush) begin
                     state_d = StIdle;
                  end else begin
                     state_d  = StDone;
                     buserr_d = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            if (bus.flush || bus.advance) begin
               state_d  = StIdle;
               result_d = 32'd0;
               fault_d  = 1'b0;
               buserr_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         addr_d    = bus.addr;
         f3_d      = bus.funct3;
         is_load_d = bus.dren_mem;
         store_d   = legal ? lane_store : 32'd0;
         byteen_d  = legal ? lane_byteen : 4'b0000;
         cnt_d     = 32'd0;
         flushed_d = 1'b0;
         result_d  = 32'd0;
         fault_d   = ~legal;
         buserr_d  = 1'b0;
         state_d   = legal ? StReq : StDone;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= StIdle;
         addr_q    <= 32'd0;
         f3_q      <= 3'd0;
         is_load_q <= 1'b0;
         store_q   <= 32'd0;
         byteen_q  <= 4'd0;
         cnt_q     <= 32'd0;
         flushed_q <= 1'b0;
         result_q  <= 32'd0;
         fault_q   <= 1'b0;
         buserr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         f3_q      <= f3_d;
         is_load_q <= is_load_d;
         store_q   <= store_d;
         byteen_q  <= byteen_d;
         cnt_q     <= cnt_d;
         flushed_q <= flushed_d;
         result_q  <= result_d;
         fault_q   <= fault_d;
         buserr_q  <= buserr_d;
      end
   end

   assign bus.dmemREN          = (state_q == StReq) & is_load_q;
   assign bus.dmemWEN          = (state_q == StReq) & ~is_load_q;
   assign bus.dmemaddr         = {addr_q[31:2], 2'b00};
   assign bus.dmemstore        = store_q;
   assign bus.dmembyteen       = byteen_q;
   assign bus.dmemload_mem     = result_q;
   assign bus.mem_stall        = (state_q == StReq) | ((state_q == StIdle) & req_valid);
   assign bus.mem_done         = (state_q == StDone);
   assign bus.misaligned_fault = fault_q;
   assign bus.bus_error        = buserr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses against a
// behavioural model of the load/store rules.
module tb_mem_access_ctrl;
   localparam int unsigned TO = 4;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_legal(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
      int sz;
      if (rd == wr) return 1'b0;
      if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
      sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      return (a % sz) == 0;
   endfunction

   function automatic logic [3:0] ref_byteen(logic wr, logic [2:0] f3, logic [31:0] a);
      if (!wr) return 4'h0;
      if (f3 == 3'd0) return 4'(1 << (a % 4));
      if (f3 == 3'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_store(logic [2:0] f3, logic [31:0] d);
      if (f3 == 3'd0) return (d % 256) * 32'h0101_0101;
      if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
      logic [31:0] b, h;
      int sh;
      sh = 8 * int'(a % 4);
      b  = (w >> sh) % 256;
      h  = (w >> sh) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic drive_idle();
      bus.mem_valid = 1'b0;
      bus.dren_mem  = 1'b0;
      bus.dwen_mem  = 1'b0;
      bus.flush     = 1'b0;
      bus.advance   = 1'b0;
      bus.dhit      = 1'b0;
   endtask

   task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
      bus.mem_valid  = 1'b1;
      bus.dren_mem   = rd;
      bus.dwen_mem   = wr;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.store_data = sd;
   endtask

   // Full transaction; lat = REQ cycle carrying dhit (0 = never, forcing the watchdog).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input int lat,
                            input logic [31:0] word, input int hold);
      logic        legal;
      logic [31:0] exp_res;
      int          ncyc;
      legal = ref_legal(rd, wr, f3, a);
      ncyc  = (lat == 0) ? int'(TO) : lat;
      @(negedge clk);
      drive_idle();
      present(rd, wr, f3, a, sd);
      #1;
      check("accept_stall", 32'(bus.mem_stall), 32'd1);
      check("accept_no_req", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
      exp_res = 32'd0;
      if (legal) begin
         for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            drive_idle();
            bus.addr       = $urandom;
            bus.store_data = $urandom;
            bus.dhit       = (lat != 0) && (k == lat - 1);
            bus.dmemload   = bus.dhit ? word : $urandom;
            #1;
            check("req_ren", 32'(bus.dmemREN), 32'(rd));
            check("req_wen", 32'(bus.dmemWEN), 32'(wr));
            check("req_addr", bus.dmemaddr, a & 32'hFFFF_FFFC);
            check("req_byteen", 32'(bus.dmembyteen), 32'(ref_byteen(wr, f3, a)));
            if (wr) check("req_store", bus.dmemstore, ref_store(f3, sd));
            check("req_stall", 32'(bus.mem_stall), 32'd1);
            check("req_not_done", 32'(bus.mem_done), 32'd0);
         end
         if (rd && lat != 0) exp_res = ref_load(f3, a, word);
      end
      @(negedge clk);
      drive_idle();
      #1;
      check("done_flag", 32'(bus.mem_done), 32'd1);
      check("done_stall", 32'(bus.mem_stall), 32'd0);
      check("done_req_off", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
      check("done_result", bus.dmemload_mem, exp_res);
      check("done_fault", 32'(bus.misaligned_fault), 32'(!legal));
      check("done_buserr", 32'(bus.bus_error), 32'(legal && lat == 0));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         drive_idle();
         present(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'd0);
         bus.dhit = 1'($urandom);
         #1;
         check("hold_done", 32'(bus.mem_done), 32'd1);
         check("hold_result", bus.dmemload_mem, exp_res);
         check("hold_no_req", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
      end
      @(negedge clk);
      drive_idle();
      bus.advance = 1'b1;
      @(negedge clk);
      drive_idle();
      #1;
      check("after_adv_done", 32'(bus.mem_done), 32'd0);
      check("after_adv_flags", 32'({bus.misaligned_fault, bus.bus_error}), 32'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic        rd, wr;
      int          kind, lat;
      drive_idle();
      bus.funct3     = 3'd0;
      bus.addr       = 32'd0;
      bus.store_data = 32'd0;
      bus.dmemload   = 32'd0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_ctrl", 32'({bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.mem_done,
                             bus.misaligned_fault, bus.bus_error}), 32'd0);
      check("rst_addr", bus.dmemaddr, 32'd0);
      check("rst_store", bus.dmemstore, 32'd0);
      check("rst_byteen", 32'(bus.dmembyteen), 32'd0);
      check("rst_load", bus.dmemload_mem, 32'd0);
      nrst = 1'b1;

      do_access(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF, 2);
      do_access(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234, 0);
      do_access(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0, 2, 32'h80FF_1234, 0);
      do_access(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'd0, 1, 32'h80FF_1234, 1);
      do_access(1'b0, 1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 2, 32'd0, 0);
      do_access(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 1, 32'd0, 0);
      do_access(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'd0, 1, 32'd0, 1);
      do_access(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'd0, 1, 32'd0, 0);
      do_access(1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'd0, 1, 32'd0, 0);
      do_access(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 0, 32'd0, 1);

      // Flush during REQ: the issued read completes but retires with no result.
      @(negedge clk);
      present(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'd0);
      @(negedge clk);
      drive_idle();
      bus.flush = 1'b1;
      #1;
      check("flush_req_held", 32'(bus.dmemREN), 32'd1);
      @(negedge clk);
      drive_idle();
      bus.dhit     = 1'b1;
      bus.dmemload = 32'h1111_2222;
      #1;
      check("flush_still_stall", 32'(bus.mem_stall), 32'd1);
      repeat (2) begin
         @(negedge clk);
         drive_idle();
         #1;
         check("flush_no_done", 32'(bus.mem_done), 32'd0);
         check("flush_req_off", 32'(bus.dmemREN), 32'd0);
      end

      // Asynchronous reset in the middle of REQ.
      @(negedge clk);
      present(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'd0);
      @(negedge clk);
      drive_idle();
      #1;
      check("pre_rst_ren", 32'(bus.dmemREN), 32'd1);
      #1 nrst = 1'b0;
      #1;
      check("async_rst_ctrl", 32'({bus.dmemREN, bus.dmemWEN, bus.mem_stall, bus.mem_done,
                                   bus.misaligned_fault, bus.bus_error}), 32'd0);
      check("async_rst_addr", bus.dmemaddr, 32'd0);
      check("async_rst_load", bus.dmemload_mem, 32'd0);
      @(negedge clk);
      nrst = 1'b1;

      // Back-to-back loads: advance in DONE accepts the next request directly.
      @(negedge clk);
      present(1'b1, 1'b0, 3'd2, 32'h0000_0600, 32'd0);
      @(negedge clk);
      drive_idle();
      bus.dhit     = 1'b1;
      bus.dmemload = 32'hCAFE_0001;
      @(negedge clk);
      drive_idle();
      present(1'b1, 1'b0, 3'd2, 32'h0000_0704, 32'd0);
      bus.advance = 1'b1;
      #1;
      check("b2b_first_result", bus.dmemload_mem, 32'hCAFE_0001);
      @(negedge clk);
      drive_idle();
      bus.dhit     = 1'b1;
      bus.dmemload = 32'hCAFE_0002;
      #1;
      check("b2b_second_ren", 32'(bus.dmemREN), 32'd1);
      check("b2b_second_addr", bus.dmemaddr, 32'h0000_0704);
      @(negedge clk);
      drive_idle();
      #1;
      check("b2b_second_done", 32'(bus.mem_done), 32'd1);
      check("b2b_second_result", bus.dmemload_mem, 32'hCAFE_0002);
      @(negedge clk);
      drive_idle();
      bus.advance = 1'b1;

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         rd   = (kind <= 5);
         wr   = (kind == 0) || (kind >= 6);
         f3   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 4) != 0) begin
            if (wr && !rd) f3 = 3'($urandom_range(0, 2));
            else if (rd) f3 = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2))
                                                           : 3'($urandom_range(4, 5));
         end
         lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
         do_access(rd, wr, f3, $urandom, $urandom, lat, $urandom, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_timeout: observed no completion expected finish");
      $fatal(1, "simulation time limit expired");
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller for the 5-stage RISC-V pipeline.
- Takes the MEM-stage load/store request, issues word-addressed dcache requests with byte enables and waits for dhit.
- Aligns and sign-extends load data, then holds the result until the MEM/WB latch advances.
- Produces the stall/done signals that gate pipeline advance and the dmemload_mem value consumed by MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for dhit before bus_error; 0 disables the watchdog.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- mem_valid  input  1  valid instruction in MEM stage
- dren_mem  input  1  instruction is a load
- dwen_mem  input  1  instruction is a store
- funct3  input  3  access size/sign
- addr  input  32  byte address (ALU result)
- store_data  input  32  rs2 value
- flush  input  1  squash the MEM-stage instruction
- advance  input  1  MEM/WB latch is capturing this cycle
- dhit  input  1  cache completes the request this cycle
- dmemload  input  32  cache read word
- dmemREN  output  1  cache read request
- dmemWEN  output  1  cache write request
- dmemaddr  output  32  word address, {addr[31:2],2'b00}
- dmemstore  output  32  lane-replicated store word
- dmembyteen  output  4  byte write enables
- dmemload_mem  output  32  aligned/extended load result
- mem_stall  output  1  hold earlier stages
- mem_done  output  1  result valid, waiting for advance
- misaligned_fault  output  1  misaligned or illegal access
- bus_error  output  1  watchdog expired

Behaviour:
- Reset: all outputs are 0 and the FSM is IDLE. Assertion mid-transaction drops dmemREN/dmemWEN immediately with no completion.
- FSM states: IDLE, REQ, DONE.
- IDLE, with mem_valid & (dren_mem|dwen_mem) & !flush:
  - Access legal and aligned: latch addr/funct3/data/byteen, then go to REQ. mem_stall=1 combinationally in this cycle.
  - Illegal: go to DONE with misaligned_fault=1, dmemload_mem=0, and no cache request.
  - Both dren_mem and dwen_mem set counts as illegal.
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Anything else is illegal.
- Alignment: lh/lhu/sh require addr[0]=0; lw/sw require addr[1:0]=0.
- REQ:
  - dmemREN or dmemWEN is held high with stable addr/data and mem_stall=1.
  - On dhit, the load word is sampled this cycle, the request drops the next cycle, and the FSM goes to DONE.
  - Minimum latency is accept→REQ (1 cycle) → dhit → DONE, so mem_done rises at the earliest 2 cycles after acceptance.
- Watchdog:
  - The counter resets on entry to REQ and increments each REQ cycle without dhit.
  - When it reaches TIMEOUT_CYCLES: go to DONE with bus_error=1, dmemload_mem=0, and the request dropped.
- DONE:
  - mem_done=1, mem_stall=0, outputs held.
  - advance or flush → IDLE and clear mem_done/fault/bus_error.
  - If advance coincides with a new valid request, the new request is accepted directly (DONE→REQ); no idle bubble.
- flush in REQ cannot abort an issued transaction: the FSM waits for dhit or timeout, then goes to IDLE (not DONE) with no result.
- flush in IDLE ignores the request.
- Store lanes:
  - sb: byteen = 1<<addr[1:0], data = {4{store_data[7:0]}}.
  - sh: byteen = 0011 if addr[1]=0, else 1100; data = {2{store_data[15:0]}}.
  - sw: byteen = 1111.
- Loads: byteen=0000. The byte/half lane is selected by addr[1:0]; sign-extended for lb/lh, zero-extended for lbu/lhu.
- The dhit and advance inputs are ignored in states where they are not expected.

Test Plan:
- lw, addr=0x100, dhit on 3rd REQ cycle, dmemload=0xDEADBEEF → dmemREN high 3 cycles, dmemaddr=0x100; next cycle mem_done=1, dmemload_mem=0xDEADBEEF; held until advance.
- lb at 0x103 and lbu at 0x103, dmemload=0x80FF1234 → dmemload_mem=0xFFFFFF80 and 0x00000080 respectively; lh at 0x102 → 0xFFFF80FF.
- sb at 0x201, store_data=0x000000AB → dmemWEN=1, dmembyteen=0010, dmemstore=0xABABABAB, dmemaddr=0x200; sh at 0x202, data 0x1234 → byteen 1100, dmemstore=0x12341234.
- lw at 0x102 → no dmemREN ever asserted, misaligned_fault=1 with mem_done=1 the next cycle; funct3=011 load → same behaviour.
- TIMEOUT_CYCLES=4, dhit held low → bus_error=1 after 4 REQ cycles, dmemREN drops; flush asserted during REQ then dhit → returns to IDLE with mem_done never asserted.
- nRST asserted during REQ → dmemREN falls immediately without waiting for CLK, all outputs 0; back-to-back lw with advance in DONE → second dmemREN asserted the cycle after advance.
